// File: rtl/harvos_dma_firewall_mpu_if.sv
// Bus bundle for the DMA firewall.
//
// Groups the DMA request/response side and the forwarded SoC bus side.
//   slave  : the firewall view (takes dma_*, drives fw_*, takes m_*)
//   master : the DMA agent / bus model view (drives dma_*, takes fw_*, drives m_*)
//
// Handshake: dma_req is a one-cycle request strobe and is only accepted while
// the firewall is idle. Each accepted request gets exactly one dma_done pulse;
// dma_fault and dma_rdata are meaningful only in that pulse. fw_req is a
// one-cycle forward strobe. m_rvalid is a one-cycle response strobe that is
// honoured only while a forwarded request is outstanding.
interface harvos_dma_firewall_mpu_if;
  logic        dma_req;
  logic        dma_we;
  logic [3:0]  dma_be;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_done;
  logic        dma_fault;
  logic [31:0] dma_rdata;

  logic        fw_req;
  logic        fw_we;
  logic [3:0]  fw_be;
  logic [31:0] fw_addr;
  logic [31:0] fw_wdata;

  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_fault;

  modport slave (
    input  dma_req, dma_we, dma_be, dma_addr, dma_wdata,
    output dma_done, dma_fault, dma_rdata,
    output fw_req, fw_we, fw_be, fw_addr, fw_wdata,
    input  m_rdata, m_rvalid, m_fault
  );

  modport master (
    output dma_req, dma_we, dma_be, dma_addr, dma_wdata,
    input  dma_done, dma_fault, dma_rdata,
    input  fw_req, fw_we, fw_be, fw_addr, fw_wdata,
    output m_rdata, m_rvalid, m_fault
  );
endinterface

// File: rtl/harvos_dma_firewall_mpu.sv
// DMA firewall / memory protection unit.
//
// Screens DMA requests against an instruction-space write guard and NREG
// programmable address/mask regions. Allowed requests are latched and
// forwarded to the SoC bus; blocked requests and bus timeouts are reported
// back to the DMA and recorded in a sticky first-fault log with a
// saturating fault counter.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bus             DMA side and forwarded bus side (slave modport)
//   cfg_*           region programming port; cfg_lock freezes regions until reset
//   flt_*           first-fault log, saturating fault count, flt_clr clears it
//   dbg_state       current FSM state (IDLE=0, FWD=1, WAIT=2, FAULT=3)
module harvos_dma_firewall_mpu #(
  parameter int NREG        = 4,
  parameter int ROM_BYTES   = 16384,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  harvos_dma_firewall_mpu_if.slave bus,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_idx,
  input  logic [31:0] cfg_base,
  input  logic [31:0] cfg_mask,
  input  logic [1:0]  cfg_mode,
  input  logic        cfg_lock,
  output logic        flt_valid,
  output logic [1:0]  flt_cause,
  output logic [2:0]  flt_region,
  output logic [31:0] flt_addr,
  output logic        flt_we,
  output logic [7:0]  flt_cnt,
  input  logic        flt_clr,
  output logic [1:0]  dbg_state
);

  localparam logic [31:0] ROM_LIM  = 32'(ROM_BYTES);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FWD   = 2'd1,
    S_WAIT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [31:0] reg_base [NREG];
  logic [31:0] reg_mask [NREG];
  logic [1:0]  reg_mode [NREG];
  logic        lock;
  logic [7:0]  wait_cnt;

  logic        blk;
  logic [1:0]  blk_cause;
  logic [2:0]  blk_region;
  logic        accept, rsp_ok, tmo;
  logic        flt_ev;
  logic [1:0]  ev_cause;
  logic [2:0]  ev_region;
  logic [31:0] ev_addr;
  logic        ev_we;

  // Block decision. mode bit0 blocks writes, bit1 blocks reads. Regions are
  // scanned from the top down so the lowest-index blocking hit is what remains.
  always_comb begin
    blk        = 1'b0;
    blk_cause  = 2'b00;
    blk_region = 3'd0;
    if (bus.dma_we && (bus.dma_addr < ROM_LIM)) begin
      blk       = 1'b1;
      blk_cause = 2'b01;
    end else begin
      for (int i = NREG - 1; i >= 0; i--) begin
        if (((bus.dma_addr & ~reg_mask[i]) == reg_base[i]) &&
            (bus.dma_we ? reg_mode[i][0] : reg_mode[i][1])) begin
          blk        = 1'b1;
          blk_cause  = 2'b10;
          blk_region = 3'(i);
        end
      end
    end
  end

  assign accept = (state == S_IDLE) && bus.dma_req;
  assign rsp_ok = (state == S_WAIT) && bus.m_rvalid;
  // A response arriving on the last WAIT cycle beats the timeout.
  assign tmo    = (state == S_WAIT) && !bus.m_rvalid && (wait_cnt == TMO_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = blk ? S_FAULT : S_FWD;
      S_FWD:   state_nx = S_WAIT;
      S_WAIT:  if (rsp_ok || tmo) state_nx = S_IDLE;
      S_FAULT: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.dma_done  = (state == S_FAULT) || rsp_ok || tmo;
  assign bus.dma_fault = (state == S_FAULT) || tmo || (rsp_ok && bus.m_fault);
  assign bus.dma_rdata = (rsp_ok && !bus.m_fault && !bus.fw_we) ? bus.m_rdata : 32'h0;
  assign dbg_state     = state;

  // Firewall faults only; bus errors reported through m_fault are not logged.
  // Timeouts log the latched request, which the fw_* registers hold.
  assign flt_ev    = (accept && blk) || tmo;
  assign ev_cause  = tmo ? 2'b11 : blk_cause;
  assign ev_region = tmo ? 3'd0 : blk_region;
  assign ev_addr   = tmo ? bus.fw_addr : bus.dma_addr;
  assign ev_we     = tmo ? bus.fw_we : bus.dma_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      wait_cnt     <= 8'd0;
      bus.fw_req   <= 1'b0;
      bus.fw_we    <= 1'b0;
      bus.fw_be    <= 4'h0;
      bus.fw_addr  <= 32'h0;
      bus.fw_wdata <= 32'h0;
    end else begin
      state      <= state_nx;
      wait_cnt   <= (state == S_WAIT) ? wait_cnt + 8'd1 : 8'd0;
      bus.fw_req <= accept && !blk;
      // fw_* double as the latched transaction for the rest of its lifetime.
      if (accept && !blk) begin
        bus.fw_we    <= bus.dma_we;
        bus.fw_be    <= bus.dma_be;
        bus.fw_addr  <= bus.dma_addr;
        bus.fw_wdata <= bus.dma_wdata;
      end
    end
  end

  // Region registers. The old lock value gates the write, so a write issued
  // together with cfg_lock still lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        reg_base[i] <= 32'h0;
        reg_mask[i] <= 32'hFFFF_FFFF;
        reg_mode[i] <= 2'b00;
      end
    end else begin
      lock <= lock | cfg_lock;
      for (int i = 0; i < NREG; i++) begin
        if (cfg_we && !lock && (cfg_idx == 3'(i))) begin
          reg_base[i] <= cfg_base;
          reg_mask[i] <= cfg_mask;
          reg_mode[i] <= cfg_mode;
        end
      end
    end
  end

  // Fault log. A fault coinciding with flt_clr starts a fresh log.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_valid  <= 1'b0;
      flt_cause  <= 2'b00;
      flt_region <= 3'd0;
      flt_addr   <= 32'h0;
      flt_we     <= 1'b0;
      flt_cnt    <= 8'd0;
    end else begin
      if (flt_clr) begin
        flt_valid <= flt_ev;
        flt_cnt   <= flt_ev ? 8'd1 : 8'd0;
      end else if (flt_ev) begin
        if (flt_cnt != 8'hFF) flt_cnt <= flt_cnt + 8'd1;
        if (!flt_valid) flt_valid <= 1'b1;
      end
      if (flt_ev && (flt_clr || !flt_valid)) begin
        flt_cause  <= ev_cause;
        flt_region <= ev_region;
        flt_addr   <= ev_addr;
        flt_we     <= ev_we;
      end
    end
  end

endmodule

// File: tb/tb_harvos_dma_firewall_mpu.sv
module tb_harvos_dma_firewall_mpu;
  localparam int NREG        = 4;
  localparam int ROM_BYTES   = 16384;
  localparam int TIMEOUT_CYC = 64;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_base;
  logic [31:0] cfg_mask;
  logic [1:0]  cfg_mode;
  logic        cfg_lock;
  logic        flt_valid;
  logic [1:0]  flt_cause;
  logic [2:0]  flt_region;
  logic [31:0] flt_addr;
  logic        flt_we;
  logic [7:0]  flt_cnt;
  logic        flt_clr;
  logic [1:0]  dbg_state;

  harvos_dma_firewall_mpu_if bus();

  harvos_dma_firewall_mpu #(
    .NREG(NREG), .ROM_BYTES(ROM_BYTES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_mask(cfg_mask),
    .cfg_mode(cfg_mode), .cfg_lock(cfg_lock),
    .flt_valid(flt_valid), .flt_cause(flt_cause), .flt_region(flt_region),
    .flt_addr(flt_addr), .flt_we(flt_we), .flt_cnt(flt_cnt), .flt_clr(flt_clr),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  int fw_pulses = 0;
  logic [32:0] exp_q[$];   // {dma_fault, dma_rdata}

  // fault-log model
  logic        m_valid;
  logic [1:0]  m_cause;
  logic [2:0]  m_region;
  logic [31:0] m_addr;
  logic        m_we;
  int          m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Monitor: every dma_done pulse is matched against the expected queue.
  always @(negedge clk) begin
    logic [32:0] e;
    if (bus.dma_done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(bus.dma_done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("dma_rsp", {31'b0, bus.dma_fault, bus.dma_rdata}, {31'b0, e});
      end
    end
    if (bus.fw_req === 1'b1) fw_pulses++;
  end

  // ---------------- model helpers ----------------
  task automatic model_clear();
    m_valid = 1'b0; m_cnt = 0;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_cause = 2'b00; m_region = 3'd0; m_addr = 32'h0; m_we = 1'b0; m_cnt = 0;
  endtask

  task automatic model_fault(input logic [1:0] cause, input logic [2:0] region,
                             input logic [31:0] addr, input logic we);
    if (!m_valid) begin
      m_valid = 1'b1; m_cause = cause; m_region = region; m_addr = addr; m_we = we;
    end
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic check_log(input string tag);
    check({tag, "_flt_valid"}, 64'(flt_valid), 64'(m_valid));
    check({tag, "_flt_cnt"}, 64'(flt_cnt), 64'(m_cnt));
    if (m_valid) begin
      check({tag, "_flt_cause"}, 64'(flt_cause), 64'(m_cause));
      check({tag, "_flt_region"}, 64'(flt_region), 64'(m_region));
      check({tag, "_flt_addr"}, 64'(flt_addr), 64'(m_addr));
      check({tag, "_flt_we"}, 64'(flt_we), 64'(m_we));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int start);
    int n = 0;
    while (done_cnt == start && n < 200) begin
      tick();
      n++;
    end
    check("done_within_budget", 64'(done_cnt != start), 64'd1);
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [31:0] base,
                           input logic [31:0] mask, input logic [1:0] mode, input logic lk);
    tick();
    cfg_we = 1'b1; cfg_idx = idx; cfg_base = base; cfg_mask = mask; cfg_mode = mode; cfg_lock = lk;
    tick();
    cfg_we = 1'b0; cfg_lock = 1'b0;
  endtask

  task automatic clear_log();
    tick();
    flt_clr = 1'b1;
    model_clear();
    tick();
    flt_clr = 1'b0;
    check("clr_flt_valid", 64'(flt_valid), 64'd0);
    check("clr_flt_cnt", 64'(flt_cnt), 64'd0);
  endtask

  task automatic do_blocked(input logic we, input logic [31:0] addr, input logic clr,
                            input logic [1:0] cause, input logic [2:0] region, input logic log_chk);
    int d0 = done_cnt;
    int f0 = fw_pulses;
    exp_q.push_back({1'b1, 32'h0});
    tick();
    bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr;
    bus.dma_be = 4'hF; bus.dma_wdata = $urandom; flt_clr = clr;
    if (clr) model_clear();
    model_fault(cause, region, addr, we);
    tick();
    bus.dma_req = 1'b0; flt_clr = 1'b0;
    check("blk_done_latency", {62'b0, bus.dma_done, bus.dma_fault}, 64'd3);
    wait_done(d0);
    check("blk_no_fw_req", 64'(fw_pulses), 64'(f0));
    if (log_chk) check_log("blk");
  endtask

  task automatic do_fwd(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input int delay, input logic [31:0] rdata, input logic mfault);
    int d0 = done_cnt;
    int f0 = fw_pulses;
    logic [31:0] wd;
    wd = $urandom;
    exp_q.push_back({mfault, (we || mfault) ? 32'h0 : rdata});
    tick();
    bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_be = be; bus.dma_wdata = wd;
    tick();
    bus.dma_req = 1'b0;
    check("fwd_fw_req", 64'(bus.fw_req), 64'd1);
    check("fwd_fw_addr", 64'(bus.fw_addr), 64'(addr));
    check("fwd_fw_we_be", {59'b0, bus.fw_we, bus.fw_be}, {59'b0, we, be});
    check("fwd_fw_wdata", 64'(bus.fw_wdata), 64'(wd));
    tick();
    repeat (delay) tick();
    bus.m_rvalid = 1'b1; bus.m_rdata = rdata; bus.m_fault = mfault;
    tick();
    bus.m_rvalid = 1'b0; bus.m_fault = 1'b0; bus.m_rdata = 32'hDEAD_BEEF;
    wait_done(d0);
    check("fwd_one_fw_pulse", 64'(fw_pulses), 64'(f0 + 1));
    check_log("fwd");
  endtask

  task automatic do_timeout(input logic [31:0] addr);
    int d0 = done_cnt;
    int k = 0;
    exp_q.push_back({1'b1, 32'h0});
    model_fault(2'b11, 3'd0, addr, 1'b0);
    tick();
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = addr; bus.dma_be = 4'hF;
    tick();
    bus.dma_req = 1'b0;
    tick();
    while (k < 100) begin
      @(negedge clk);
      if (bus.dma_done === 1'b1) break;
      tick();
      k++;
    end
    check("tmo_wait_cycle", 64'(k), 64'(TIMEOUT_CYC - 1));
    wait_done(d0);
    tick();
    check_log("tmo");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    rst = 1'b1;
    cfg_we = 1'b0; cfg_idx = 3'd0; cfg_base = 32'h0; cfg_mask = 32'h0; cfg_mode = 2'b00;
    cfg_lock = 1'b0; flt_clr = 1'b0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_be = 4'h0; bus.dma_addr = 32'h0;
    bus.dma_wdata = 32'h0; bus.m_rdata = 32'h0; bus.m_rvalid = 1'b0; bus.m_fault = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done_fault", {62'b0, bus.dma_done, bus.dma_fault}, 64'd0);
    check("rst_rdata", 64'(bus.dma_rdata), 64'd0);
    check("rst_fw_req", 64'(bus.fw_req), 64'd0);
    check("rst_fw_addr", 64'(bus.fw_addr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check_log("rst");
    tick();
    rst = 1'b0;

    // I-space write guard
    do_blocked(1'b1, 32'h0000_0100, 1'b0, 2'b01, 3'd0, 1'b1);
    clear_log();
    // reads of I-space are fine
    do_fwd(1'b0, 32'h0000_0100, 4'hF, 3, 32'hA5A5_0001, 1'b0);

    // region 2: block reads
    cfg_write(3'd2, 32'h4000_0000, 32'h0000_0FFF, 2'b10, 1'b0);
    do_blocked(1'b0, 32'h4000_0010, 1'b0, 2'b10, 3'd2, 1'b1);
    do_fwd(1'b1, 32'h4000_0010, 4'h3, 0, 32'h1111_2222, 1'b0);

    // regions 1 and 3 overlap: lowest index reported
    clear_log();
    cfg_write(3'd1, 32'h2000_0000, 32'h0000_00FF, 2'b11, 1'b0);
    cfg_write(3'd3, 32'h2000_0000, 32'h0000_00FF, 2'b11, 1'b0);
    do_blocked(1'b1, 32'h2000_0004, 1'b0, 2'b10, 3'd1, 1'b1);
    // second fault does not overwrite the log
    do_blocked(1'b0, 32'h2000_0008, 1'b0, 2'b10, 3'd1, 1'b1);
    // bus error: reported, not logged
    do_fwd(1'b0, 32'h3000_0000, 4'hF, 1, 32'h5555_5555, 1'b1);

    // timeout, then response on the last WAIT cycle
    clear_log();
    do_timeout(32'h5000_0000);
    do_fwd(1'b0, 32'h5000_0040, 4'hF, TIMEOUT_CYC - 1, 32'h1234_5678, 1'b0);

    // lock with simultaneous write, then attempted rewrite
    clear_log();
    cfg_write(3'd0, 32'h6000_0000, 32'h0000_000F, 2'b01, 1'b1);
    cfg_write(3'd0, 32'h6000_0000, 32'h0000_000F, 2'b00, 1'b0);
    do_blocked(1'b1, 32'h6000_0004, 1'b0, 2'b10, 3'd0, 1'b1);
    do_fwd(1'b0, 32'h6000_0004, 4'hF, 2, 32'h0BAD_F00D, 1'b0);

    // clear coincident with a fault
    do_blocked(1'b1, 32'h6000_000C, 1'b1, 2'b10, 3'd0, 1'b1);

    // saturation
    for (int i = 0; i < 300; i++)
      do_blocked(1'b1, 32'h0000_0200 + 32'(i * 4), 1'b0, 2'b01, 3'd0, 1'b0);
    tick();
    check_log("sat");

    // reset in WAIT
    d0 = done_cnt;
    tick();
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h7000_0000; bus.dma_be = 4'hF;
    tick();
    bus.dma_req = 1'b0;
    tick();
    repeat (3) tick();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("mid_rst_done_fault", {62'b0, bus.dma_done, bus.dma_fault}, 64'd0);
    check("mid_rst_rdata", 64'(bus.dma_rdata), 64'd0);
    check("mid_rst_fw", {31'b0, bus.fw_req, bus.fw_addr}, 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    check_log("mid_rst");
    tick();
    rst = 1'b0;
    tick();
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'hCAFE_0000;
    tick();
    bus.m_rvalid = 1'b0;
    repeat (3) tick();
    check("late_rvalid_no_done", 64'(done_cnt), 64'(d0));
    // lock and regions were cleared by reset
    do_fwd(1'b1, 32'h6000_0004, 4'hF, 1, 32'h0, 1'b0);

    repeat (2) tick();
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
